// File: rtl/prime_scan_driver_pkg.sv
// prime_pkg: shared state encoding and parameter defaults for the prime scan driver.
package prime_pkg;
    localparam int NUM_W_D  = 10;
    localparam int CNT_W_D  = 8;
    localparam int TO_CYC_D = 4096;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_WAIT, S_EMIT, S_NEXT} state_t;
endpackage

// File: rtl/prime_scan_driver_if.sv
// prime_scan_driver_if: checker handshake plus prime output stream.
interface prime_scan_driver_if #(parameter int NUM_W = 10);
    logic             chk_start;
    logic             chk_done;
    logic             chk_prime;
    logic [NUM_W-1:0] chk_num;
    logic             prime_valid;
    logic [NUM_W-1:0] prime_val;
    logic             prime_ready;
    modport master (
        output chk_start, chk_num, prime_valid, prime_val,
        input  chk_done, chk_prime, prime_ready
    );
    modport slave (
        input  chk_start, chk_num, prime_valid, prime_val,
        output chk_done, chk_prime, prime_ready
    );
endinterface

// File: rtl/prime_scan_driver_out_reg.sv
// prime_out_reg: single-entry valid/ready holding register for found primes.
module prime_out_reg
    import prime_pkg::*;
#(
    parameter int W = NUM_W_D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_val
);
    logic         r_valid;
    logic [W-1:0] r_val;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_val   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_val   <= i_val;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end
    assign o_valid = r_valid;
    assign o_val   = r_val;
endmodule

// File: rtl/prime_scan_driver.sv
// prime_scan_driver: walks [lo,hi] through the prime checker and streams primes found.
// Optional WATCHDOG_EN bounds each check to TO_CYC cycles and flags err on expiry.
module prime_scan_driver
    import prime_pkg::*;
#(
    parameter int NUM_W  = NUM_W_D,
    parameter int CNT_W  = CNT_W_D,
    parameter int TO_CYC = TO_CYC_D
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [NUM_W-1:0]     lo,
    input  logic [NUM_W-1:0]     hi,
    prime_scan_driver_if.master  bus,
    output logic                 busy,
    output logic                 scan_done,
    output logic [CNT_W-1:0]     prime_cnt,
    output logic                 err
);
    state_t           r_state;
    logic [NUM_W-1:0] r_cur;
    logic [NUM_W-1:0] r_hi;
    logic             r_start;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic             w_to;
    logic             w_go;
    logic             w_load;
    assign w_go   = r_state == S_IDLE && go && lo <= hi;
    assign w_load = r_state == S_WAIT && bus.chk_done && bus.chk_prime && !w_to;
`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TO_CYC + 1);
    logic [WD_W-1:0] r_wd;
    logic            r_err;
    assign w_to = (r_state == S_REQ || r_state == S_WAIT) && r_wd == WD_W'(TO_CYC - 1);
    always_ff @(posedge clk) begin
        if (reset || r_state == S_SETUP)
            r_wd <= '0;
        else if (r_state == S_REQ || r_state == S_WAIT)
            r_wd <= r_wd + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset || w_go)
            r_err <= 1'b0;
        else if (w_to)
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign w_to = 1'b0;
    assign err  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_hi    <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (go) begin
                    r_cnt <= '0;
                    if (w_go) begin
                        r_cur   <= lo;
                        r_hi    <= hi;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_start <= 1'b1;
                    r_state <= S_REQ;
                end
                // done low means the checker took the request; holding start longer re-arms it
                S_REQ: if (!bus.chk_done) begin
                    r_start <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (bus.chk_done) begin
                    if (bus.chk_prime && r_cnt != '1)
                        r_cnt <= r_cnt + 1'b1;
                    r_state <= bus.chk_prime ? S_EMIT : S_NEXT;
                end
                S_EMIT: if (bus.prime_valid && bus.prime_ready)
                    r_state <= S_NEXT;
                S_NEXT: if (r_cur == r_hi) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    r_cur   <= r_cur + 1'b1;
                    r_state <= S_SETUP;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_to) begin
                r_start <= 1'b0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
            end
        end
    end
    prime_out_reg #(.W(NUM_W)) u_out (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_val   (r_cur),
        .i_ready (bus.prime_ready),
        .o_valid (bus.prime_valid),
        .o_val   (bus.prime_val)
    );
    assign bus.chk_start = r_start;
    assign bus.chk_num   = r_cur;
    assign busy          = r_busy;
    assign scan_done     = r_done;
    assign prime_cnt     = r_cnt;
endmodule

// File: tb/tb_prime_scan_driver.sv
// tb_prime_scan_driver: directed and random scans against a behavioural prime checker.
module tb_prime_scan_driver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [9:0] lo_i = '0;
    logic [9:0] hi_i = '0;
    logic       busy, scan_done, err;
    logic [7:0] prime_cnt;
    logic       c_done = 1'b1;
    logic       c_prime = 1'b0;
    int total = 0, bad = 0;
    int ph = 0, t = 0, acc_dly = 0, run_dly = 0, n_starts = 0;
    int rdy_mode = 0, hold = 0, viol = 0;
    bit stuck = 0;
    logic [9:0] num_l;
    int got_q[$];
    prime_scan_driver_if #(.NUM_W(10)) bus();
    prime_scan_driver dut (
        .clk(clk), .reset(reset), .go(go), .lo(lo_i), .hi(hi_i), .bus(bus),
        .busy(busy), .scan_done(scan_done), .prime_cnt(prime_cnt), .err(err)
    );
    assign bus.chk_done  = c_done;
    assign bus.chk_prime = c_prime;
    always #5 clk = ~clk;
    function automatic bit isp(int n);
        if (n < 2) return 0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 0;
        return 1;
    endfunction
    // behavioural checker: accepts start, drops done after acc_dly, raises it after run_dly
    always @(posedge clk) begin
        if (stuck) begin
            c_done <= 1'b1;
            ph <= 0;
        end else case (ph)
            0: if (bus.chk_start) begin
                ph <= 1; t <= acc_dly; num_l <= bus.chk_num; n_starts <= n_starts + 1;
            end
            1: if (t == 0) begin c_done <= 1'b0; t <= run_dly; ph <= 2; end else t <= t - 1;
            default: if (t == 0) begin c_done <= 1'b1; c_prime <= isp(int'(num_l)); ph <= 0; end else t <= t - 1;
        endcase
    end
    always @(negedge clk) begin
        bus.prime_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : 1'b0;
        if (bus.prime_valid && bus.prime_ready) got_q.push_back(int'(bus.prime_val));
        if (bus.chk_start && !bus.chk_done) begin
            hold++;
            if (hold > 1) viol++;
        end else hold = 0;
    end
    task automatic chk(string tag, longint got, longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic chk_zero(string tag);
        chk({tag, ":busy"}, busy, 0);
        chk({tag, ":scan_done"}, scan_done, 0);
        chk({tag, ":prime_cnt"}, prime_cnt, 0);
        chk({tag, ":err"}, err, 0);
        chk({tag, ":chk_start"}, bus.chk_start, 0);
        chk({tag, ":chk_num"}, bus.chk_num, 0);
        chk({tag, ":prime_valid"}, bus.prime_valid, 0);
        chk({tag, ":prime_val"}, bus.prime_val, 0);
    endtask
    task automatic start_scan(int l, int h);
        got_q.delete();
        @(negedge clk);
        go = 1; lo_i = 10'(l); hi_i = 10'(h);
        @(negedge clk);
        go = 0;
    endtask
    task automatic finish_scan(int l, int h, int s0, string tag);
        int cyc = 0;
        int q[$];
        while (!(scan_done && !busy) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ":finished"}, cyc < 20000, 1);
        for (int n = l; n <= h; n++) if (isp(n)) q.push_back(n);
        chk({tag, ":n_primes"}, got_q.size(), q.size());
        for (int i = 0; i < q.size() && i < got_q.size(); i++)
            chk($sformatf("%s:prime[%0d]", tag, i), got_q[i], q[i]);
        chk({tag, ":prime_cnt"}, prime_cnt, q.size() > 255 ? 255 : q.size());
        chk({tag, ":starts"}, n_starts - s0, h - l + 1);
        chk({tag, ":err"}, err, 0);
        chk({tag, ":busy"}, busy, 0);
    endtask
    task automatic run_scan(int l, int h, string tag);
        int s0 = n_starts;
        start_scan(l, h);
        finish_scan(l, h, s0, tag);
    endtask
    initial begin
        int s0, cyc, unstable;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 0;
        s0 = n_starts;
        start_scan(10, 5);
        chk("inv:scan_done", scan_done, 1);
        chk("inv:prime_cnt", prime_cnt, 0);
        chk("inv:busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("inv:starts", n_starts - s0, 0);
        acc_dly = 0; run_dly = 0;
        run_scan(0, 20, "r0_20");
        run_scan(1, 1, "r1_1");
        acc_dly = 1; run_dly = 40;
        run_scan(1013, 1023, "top");
        chk("start_drop", viol, 0);
        acc_dly = 0; run_dly = 2; rdy_mode = 2;
        s0 = n_starts;
        start_scan(2, 7);
        cyc = 0;
        while (!bus.prime_valid && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("stall:valid_seen", bus.prime_valid, 1);
        unstable = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.prime_val !== 10'd2 || bus.chk_start !== 1'b0 || bus.prime_valid !== 1'b1) unstable++;
        end
        chk("stall:stable", unstable, 0);
        rdy_mode = 0;
        finish_scan(2, 7, s0, "stall");
        rdy_mode = 1;
        for (int k = 0; k < 5; k++) begin
            int l = $urandom_range(0, 1000);
            int h = l + $urandom_range(0, 23);
            if (h > 1023) h = 1023;
            acc_dly = $urandom_range(0, 3);
            run_dly = $urandom_range(0, 8);
            run_scan(l, h, $sformatf("rnd%0d", k));
        end
        rdy_mode = 0; acc_dly = 0; run_dly = 30;
        start_scan(100, 110);
        cyc = 0;
        while (!(busy && !bus.chk_start && !bus.chk_done) && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("rst_wait:reached", cyc < 2000, 1);
        reset = 1;
        @(negedge clk);
        chk_zero("rst_mid");
        reset = 0;
        cyc = 0;
        while (!(ph == 0 && c_done) && cyc < 2000) begin @(negedge clk); cyc++; end
        acc_dly = 0; run_dly = 1;
        run_scan(0, 20, "after_rst");
`ifdef WATCHDOG_EN
        stuck = 1;
        start_scan(5, 9);
        cyc = 0;
        while (!scan_done && cyc < 6000) begin @(negedge clk); cyc++; end
        chk("wd:err", err, 1);
        chk("wd:scan_done", scan_done, 1);
        chk("wd:busy", busy, 0);
        chk("wd:chk_start", bus.chk_start, 0);
        chk("wd:prime_cnt", prime_cnt, 0);
        stuck = 0;
        repeat (2) @(negedge clk);
        run_scan(2, 3, "wd_recover");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prime_scan_driver.md
Name: prime_scan_driver

Overview:
- Initiator for the prime checker's start/DONE/PRIME handshake.
- Walks an inclusive number range [lo, hi] and presents each value on chk_num. Pulses chk_start, waits for the checker to finish, then emits every prime found on a valid/ready output stream.
- Sits between board-level control (switches and buttons) and the checker instance, in the checker's source clock domain (clk).

Parameters:
- NUM_W, 10: width of tested numbers; matches the checker's num input.
- CNT_W, 8: width of the prime counter; 172 primes lie below 1024.
- TO_CYC, 4096: watchdog limit in clk cycles per check (used only with WATCHDOG_EN).

Ports:
- clk  in  1  system clock; the same clock that feeds the checker's internal divider.
- reset  in  1  synchronous, active-high reset.
- go  in  1  start a scan; sampled only in IDLE.
- lo  in  NUM_W  first value, captured when go is accepted.
- hi  in  NUM_W  last value (inclusive), captured when go is accepted.
- chk_done  in  1  checker DONE.
- chk_prime  in  1  checker PRIME; valid while chk_done=1.
- chk_start  out  1  checker start request.
- chk_num  out  NUM_W  value under test.
- prime_valid  out  1  prime_val holds a prime.
- prime_val  out  NUM_W  the prime found.
- prime_ready  in  1  downstream accepts prime_val.
- busy  out  1  scan in progress.
- scan_done  out  1  level; set on scan completion, cleared on the next accepted go.
- prime_cnt  out  CNT_W  primes found in the current scan; saturates at all-ones.
- err  out  1  sticky watchdog error; tied 0 when WATCHDOG_EN is undefined.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Clock and reset: one clock; reset is synchronous and active-high, sampled on posedge clk.
- IDLE: busy=0.
  - go=1 with lo<=hi: capture lo and hi, set cur=lo, clear prime_cnt, scan_done and err, go to SETUP.
  - go=1 with lo>hi: set scan_done=1, prime_cnt=0, stay in IDLE.
- SETUP: drive chk_num=cur for one cycle before the request, so num is stable before the checker's load edge. Go to REQ.
- REQ: chk_start=1. Hold it until chk_done is sampled 0, which means the checker has accepted and entered its work state. Then drop chk_start and go to WAIT.
  - chk_start must never remain high once chk_done=0; the checker would re-arm.
- WAIT: chk_start=0; chk_num stays at cur. When chk_done is sampled 1, latch chk_prime.
  - If chk_prime=1: load prime_val=cur, increment prime_cnt (saturating), go to EMIT.
  - Otherwise go to NEXT.
- EMIT: prime_valid=1. Advance to NEXT on the cycle prime_valid & prime_ready. prime_val is stable while stalled. Backpressure stalls the scan indefinitely.
- NEXT:
  - If cur==hi: busy=0, scan_done=1, go to IDLE.
  - Otherwise cur=cur+1, go to SETUP.
  - Compare before increment so hi=2^NUM_W-1 never wraps.
- busy=1 in every state except IDLE.
- go outside IDLE is ignored.
- Latency per non-prime number: 1 cycle (SETUP) + checker accept time + checker run time + 1 cycle (NEXT). EMIT adds at least 1 cycle per prime.
- Reset mid-scan: immediate return to IDLE, chk_start=0, prime_valid=0, any in-flight result discarded. The checker is not reset by this block.
- lo=hi is legal: exactly one check.

Optional Feature:
- Macro WATCHDOG_EN.
- Defined:
  - A counter runs in REQ and WAIT and clears on each entry to SETUP.
  - On reaching TO_CYC: err=1 (sticky until the next accepted go), chk_start=0, scan_done=1, return to IDLE. prime_cnt keeps the primes found so far.
- Undefined:
  - No counter; REQ and WAIT wait forever.
  - err is constant 0.

Decomposition:
- Package prime_pkg holds:
  - the state encoding (IDLE, SETUP, REQ, WAIT, EMIT, NEXT);
  - NUM_W and CNT_W defaults;
  - the TO_CYC default.
- One natural sub-module, prime_out_reg: a 1-entry valid/ready holding register for prime_val. Everything else stays in the top FSM.

Test Plan:
- Checker in test mode (undivided clock), go with lo=0, hi=20 -> primes streamed in order 2,3,5,7,11,13,17,19; prime_cnt=8; scan_done=1; busy=0.
- lo=hi=1 -> exactly one chk_start handshake, no prime_valid, prime_cnt=0, scan_done=1.
- lo=10, hi=5 -> no chk_start, scan_done=1 on the cycle after go, prime_cnt=0.
- lo=1013, hi=1023, checker divided by 16 -> primes 1013, 1019, 1021; no wrap past 1023; chk_start drops within 1 cycle of chk_done falling.
- lo=2, hi=7 with prime_ready held 0 for 50 cycles at the first prime -> prime_val=2 stable, chk_start stays 0; after release, 3, 5, 7 follow.
- WATCHDOG_EN defined with chk_done stuck at 1 -> after TO_CYC=4096 cycles in REQ: err=1, scan_done=1, IDLE.
- Reset asserted in WAIT -> all outputs 0 on the next cycle; a new go restarts cleanly.
